ay_write_sequencer: RTL and testbench

- Sits between the CPU port-14/15 decode and the AY glue bus (`address`, `data`, `wren`, `rden`).
- Lets a second, non-CPU requester inject AY register writes without disturbing CPU accesses. Typical requesters are the OSD sound player and the frame music loader.
- Each injected write becomes an address-latch cycle followed by a data-write cycle, each held for a fixed number of `ce` pulses.
- Afterwards the CPU's last-latched AY register address is restored, so the CPU never sees the intrusion.

---
 rtl/ay_pkg.sv | 19 +
 rtl/ay_phase_timer.sv | 37 +++
 rtl/ay_write_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ay_write_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ay_pkg.sv
// Shared definitions for the AY write sequencer.
//   ay_state_e   : sequencer FSM states
//   AY_PORT_*    : value of the AY glue `address` line for each port
//   HOLD_W       : width of the per-phase ce hold counter
package ay_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      DATA    = 2'd2,
      RESTORE = 2'd3
   } ay_state_e;

   localparam logic AY_PORT_DATA = 1'b0;
   localparam logic AY_PORT_ADDR = 1'b1;

   localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/ay_phase_timer.sv
// Counts `ce` pulses for one sequencer bus phase.
//   clk, reset_n : clock, async active-low reset
//   clear        : zero the count (phase change or CPU abort)
//   en           : count enable (sequencer owns the bus)
//   ce           : AY clock enable strobe
//   done         : the HOLD_CE-th counted pulse is present this clk
module ay_phase_timer
   import ay_pkg::*;
#(
   parameter int unsigned HOLD_CE = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   input  logic ce,
   output logic done
);

   localparam logic [HOLD_W-1:0] TERM = HOLD_W'(HOLD_CE - 1);

   logic [HOLD_W-1:0] cnt_q;

   // done is combinational so the phase ends on the edge that samples the last pulse
   assign done = en && ce && (cnt_q == TERM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear || done) begin
         cnt_q <= '0;
      end else if (en && ce) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/ay_write_sequencer.sv
// Injects AY register writes from a non-CPU requester between CPU accesses.
// Each request becomes an address-latch phase, a data-write phase and a
// phase restoring the CPU's last latched AY address.
//   clk, reset_n                    : clock, async active-low reset
//   ce                              : AY clock enable
//   cpu_address/data/wren/rden      : CPU port 14/15 access (always has priority)
//   req_valid, req_reg, req_data    : injected write request
//   req_ready                       : one-clk pulse when the data phase completes
//   ay_address/data/wren/rden       : AY glue bus
//   busy                            : sequencer not idle
// Optional: AY_SEQ_SKIP_REDUNDANT_EN skips ADDR/RESTORE phases whose address
// is already latched in the AY.
//
// state   | meaning
// IDLE    | no drive, waiting for a request
// ADDR    | latching requested register number (address port)
// DATA    | writing requested value (data port)
// RESTORE | re-latching the CPU's shadow address
module ay_write_sequencer
   import ay_pkg::*;
#(
   parameter int unsigned HOLD_CE = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       cpu_address,
   input  logic [7:0] cpu_data,
   input  logic       cpu_wren,
   input  logic       cpu_rden,
   input  logic       req_valid,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       ay_address,
   output logic [7:0] ay_data,
   output logic       ay_wren,
   output logic       ay_rden,
   output logic       busy
);

   ay_state_e  state_q, state_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] val_q, val_d;
   logic [7:0] shadow_q, shadow_d;
   logic       seq_addr_q, seq_addr_d;
   logic [7:0] seq_data_q, seq_data_d;
   logic       seq_wren_q, seq_wren_d;
   logic       req_ready_q, req_ready_d;
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
   logic [7:0] cur_addr_q;
`endif

   logic cpu_strobe, cpu_addr_wr, accept, done, tmr_clear;

   assign cpu_strobe  = cpu_wren || cpu_rden;
   assign cpu_addr_wr = cpu_wren && (cpu_address == AY_PORT_ADDR);

   // Clearing while the CPU owns the bus makes every abort restart its phase fresh.
   assign tmr_clear = cpu_strobe || (state_d != state_q);

   ay_phase_timer #(.HOLD_CE(HOLD_CE)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .en      (!cpu_strobe && (state_q != IDLE)),
      .ce      (ce),
      .done    (done)
   );

   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid && !cpu_strobe) begin
               state_d = ADDR;
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
               if (req_reg == cur_addr_q) state_d = DATA;
`endif
            end
         end
         ADDR: begin
            // CPU collisions simply hold ADDR; the timer is cleared meanwhile
            if (done) state_d = DATA;
         end
         DATA: begin
            if (cpu_addr_wr) begin
               state_d = ADDR;
            end else if (done) begin
               req_ready_d = 1'b1;
               state_d     = RESTORE;
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
               if (cur_addr_q == shadow_q) state_d = IDLE;
`endif
            end
         end
         RESTORE: begin
            // a CPU address write already re-latched the address it wants
            if (cpu_addr_wr || done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept   = (state_q == IDLE) && (state_d != IDLE);
   assign reg_d    = accept ? req_reg : reg_q;
   assign val_d    = accept ? req_data : val_q;
   assign shadow_d = cpu_addr_wr ? cpu_data : shadow_q;

   always_comb begin
      seq_addr_d = 1'b0;
      seq_data_d = 8'h00;
      seq_wren_d = 1'b0;
      unique case (state_d)
         ADDR: begin
            seq_addr_d = AY_PORT_ADDR;
            seq_data_d = reg_d;
            seq_wren_d = 1'b1;
         end
         DATA: begin
            seq_addr_d = AY_PORT_DATA;
            seq_data_d = val_d;
            seq_wren_d = 1'b1;
         end
         RESTORE: begin
            seq_addr_d = AY_PORT_ADDR;
            seq_data_d = shadow_d;
            seq_wren_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         reg_q       <= 8'h00;
         val_q       <= 8'h00;
         shadow_q    <= 8'h00;
         seq_addr_q  <= 1'b0;
         seq_data_q  <= 8'h00;
         seq_wren_q  <= 1'b0;
         req_ready_q <= 1'b0;
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
         cur_addr_q  <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         reg_q       <= reg_d;
         val_q       <= val_d;
         shadow_q    <= shadow_d;
         seq_addr_q  <= seq_addr_d;
         seq_data_q  <= seq_data_d;
         seq_wren_q  <= seq_wren_d;
         req_ready_q <= req_ready_d;
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
         if (cpu_addr_wr) begin
            cur_addr_q <= cpu_data;
         end else if (state_q == ADDR && done) begin
            cur_addr_q <= reg_q;
         end else if (state_q == RESTORE && done) begin
            cur_addr_q <= shadow_q;
         end
`endif
      end
   end

   // CPU access wins combinationally; sequencer drive is registered
   assign ay_address = cpu_strobe ? cpu_address : seq_addr_q;
   assign ay_data    = cpu_strobe ? cpu_data    : seq_data_q;
   assign ay_wren    = cpu_strobe ? cpu_wren    : seq_wren_q;
   assign ay_rden    = cpu_strobe ? cpu_rden    : 1'b0;
   assign req_ready  = req_ready_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ay_write_sequencer.sv
module tb_ay_write_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b0;
   logic       cpu_address = 1'b0;
   logic [7:0] cpu_data = 8'h00;
   logic       cpu_wren = 1'b0;
   logic       cpu_rden = 1'b0;
   logic       req_valid = 1'b0;
   logic [7:0] req_reg = 8'h00;
   logic [7:0] req_data = 8'h00;
   logic       req_ready;
   logic       ay_address;
   logic [7:0] ay_data;
   logic       ay_wren;
   logic       ay_rden;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_cnt  = 0;
   int cyc      = 0;
   logic ce_en  = 1'b1;

   localparam int LIMIT = 200;

   ay_write_sequencer #(.HOLD_CE(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ce          (ce),
      .cpu_address (cpu_address),
      .cpu_data    (cpu_data),
      .cpu_wren    (cpu_wren),
      .cpu_rden    (cpu_rden),
      .req_valid   (req_valid),
      .req_reg     (req_reg),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .ay_address  (ay_address),
      .ay_data     (ay_data),
      .ay_wren     (ay_wren),
      .ay_rden     (ay_rden),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // ce: one clk in four
   always @(negedge clk) begin
      cyc = cyc + 1;
      ce  = ce_en && (cyc % 4 == 0);
   end

   always @(negedge clk) if (req_ready) rdy_cnt = rdy_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Walk one sequencer phase from the current sample; counts ce pulses seen
   // while the bus shows {wren=1, address, data}. Leaves us on the first
   // sample after the phase.
   task automatic expect_phase(input string tag, input logic a, input logic [7:0] d, input int exp_ce);
      int n = 0;
      int ces = 0;
      logic first;
      first = ay_wren && !ay_rden && (ay_address == a) && (ay_data == d);
      check({tag, "_drive"}, {ay_wren, ay_rden, 7'b0, ay_address, ay_data},
            {1'b1, 1'b0, 7'b0, a, d});
      while (ay_wren && !ay_rden && (ay_address == a) && (ay_data == d) && n < LIMIT) begin
         if (ce) ces++;
         @(negedge clk); #1;
         n++;
      end
      if (first) begin
         check({tag, "_ce"}, ces, exp_ce);
         check({tag, "_timeout"}, (n < LIMIT), 1);
      end
   endtask

   task automatic start_req(input logic [7:0] r, input logic [7:0] v);
      req_reg   = r;
      req_data  = v;
      req_valid = 1'b1;
      @(negedge clk); #1;
      req_valid = 1'b0;
      req_reg   = 8'hEE;
      req_data  = 8'hEE;
   endtask

   task automatic cpu_cycle(input logic a, input logic [7:0] d, input logic wr);
      cpu_address = a;
      cpu_data    = d;
      cpu_wren    = wr;
      cpu_rden    = !wr;
      #1;
   endtask

   task automatic cpu_release();
      cpu_wren    = 1'b0;
      cpu_rden    = 1'b0;
      cpu_address = 1'b0;
      cpu_data    = 8'h00;
      #1;
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      #1;
      check("rst_out", {ay_wren, ay_rden, ay_address, ay_data, busy, req_ready}, 13'h0);
      reset_n = 1'b1;
      @(negedge clk); #1;

      // 1: CPU pass-through, latch shadow 0x07
      cpu_cycle(1'b1, 8'h07, 1'b1);
      check("t1_aw", {ay_wren, ay_rden, ay_address, ay_data}, {1'b1, 1'b0, 1'b1, 8'h07});
      check("t1_busy", busy, 0);
      @(negedge clk); #1;
      cpu_cycle(1'b0, 8'h38, 1'b1);
      check("t1_dw", {ay_wren, ay_rden, ay_address, ay_data}, {1'b1, 1'b0, 1'b0, 8'h38});
      @(negedge clk); #1;
      cpu_cycle(1'b0, 8'h5A, 1'b0);
      check("t1_rd", {ay_wren, ay_rden, ay_address, ay_data}, {1'b0, 1'b1, 1'b0, 8'h5A});
      @(negedge clk); #1;
      cpu_release();
      check("t1_idle", {ay_wren, ay_rden, ay_address, ay_data, busy}, 12'h0);

      // 2: plain request
      rdy_cnt = 0;
      start_req(8'h08, 8'h0F);
      check("t2_busy", busy, 1);
      expect_phase("t2_addr", 1'b1, 8'h08, 2);
      check("t2_rdy_early", rdy_cnt, 0);
      expect_phase("t2_data", 1'b0, 8'h0F, 2);
      check("t2_rdy_at_data_end", rdy_cnt, 1);
      expect_phase("t2_rest", 1'b1, 8'h07, 2);
      check("t2_idle", {ay_wren, busy}, 2'b00);
      check("t2_rdy_total", rdy_cnt, 1);

      // 3: CPU address write 0x0A during DATA
      @(negedge clk); #1;
      rdy_cnt = 0;
      start_req(8'h08, 8'h0F);
      expect_phase("t3_addr", 1'b1, 8'h08, 2);
      cpu_cycle(1'b1, 8'h0A, 1'b1);
      check("t3_pass", {ay_wren, ay_address, ay_data}, {1'b1, 1'b1, 8'h0A});
      @(negedge clk); #1;
      cpu_release();
      expect_phase("t3_addr2", 1'b1, 8'h08, 2);
      expect_phase("t3_data", 1'b0, 8'h0F, 2);
      expect_phase("t3_rest", 1'b1, 8'h0A, 2);
      check("t3_rdy", rdy_cnt, 1);
      check("t3_busy", busy, 0);

      // 4: CPU read during RESTORE
      @(negedge clk); #1;
      rdy_cnt = 0;
      start_req(8'h08, 8'h0F);
      expect_phase("t4_addr", 1'b1, 8'h08, 2);
      expect_phase("t4_data", 1'b0, 8'h0F, 2);
      cpu_cycle(1'b0, 8'h55, 1'b0);
      check("t4_pass", {ay_wren, ay_rden, ay_data}, {1'b0, 1'b1, 8'h55});
      repeat (2) @(negedge clk);
      #1;
      cpu_release();
      expect_phase("t4_rest", 1'b1, 8'h0A, 2);
      check("t4_rdy", rdy_cnt, 1);
      check("t4_busy", busy, 0);

      // 5: reset during DATA
      @(negedge clk); #1;
      rdy_cnt = 0;
      start_req(8'h08, 8'h0F);
      expect_phase("t5_addr", 1'b1, 8'h08, 2);
      reset_n = 1'b0;
      #1;
      check("t5_rst_out", {ay_wren, ay_address, ay_data, busy}, 11'h0);
      @(negedge clk); #1;
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("t5_rdy", rdy_cnt, 0);
      check("t5_idle", {busy, ay_wren}, 2'b00);

      // 6: request for the register already latched
      cpu_cycle(1'b1, 8'h08, 1'b1);
      @(negedge clk); #1;
      cpu_release();
      rdy_cnt = 0;
      start_req(8'h08, 8'h33);
`ifdef AY_SEQ_SKIP_REDUNDANT_EN
      expect_phase("t6_data", 1'b0, 8'h33, 2);
`else
      expect_phase("t6_addr", 1'b1, 8'h08, 2);
      expect_phase("t6_data", 1'b0, 8'h33, 2);
      expect_phase("t6_rest", 1'b1, 8'h08, 2);
`endif
      check("t6_rdy", rdy_cnt, 1);
      check("t6_idle", {busy, ay_wren}, 2'b00);

      // 7: ce held low freezes the sequencer
      @(negedge clk); #1;
      ce_en = 1'b0;
      rdy_cnt = 0;
      start_req(8'h0B, 8'h44);
      repeat (20) @(negedge clk);
      #1;
      check("t7_hold", {busy, ay_wren, ay_address, ay_data}, {1'b1, 1'b1, 1'b1, 8'h0B});
      ce_en = 1'b1;
      expect_phase("t7_addr", 1'b1, 8'h0B, 2);
      expect_phase("t7_data", 1'b0, 8'h44, 2);
      expect_phase("t7_rest", 1'b1, 8'h08, 2);
      check("t7_rdy", rdy_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
